// File: rtl/operand_entry.sv
// Keypad operand entry: debounced key handshake, signed decimal entry with
// range check, and a one-cycle commit of the typed operand with its operator.
module operand_entry (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_input,
  input  logic [3:0]  keypad_input,
  input  logic [2:0]  operator_input,
  input  logic        equal_input,
  output logic        key_read,
  output logic [15:0] entry_value,
  output logic [15:0] operand,
  output logic [2:0]  op_code,
  output logic        is_equal,
  output logic        operand_valid,
  output logic        entry_ovf
);

  typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;

  localparam logic [2:0] OP_SIGN  = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_CLEAR = 3'b110;

  state_t      state, state_next;
  logic [3:0]  key_digit;
  logic [2:0]  key_op;
  logic        key_eq;
  logic        capture;

  logic [14:0] mag, mag_next;
  logic        neg, neg_next;
  logic        ovf, ovf_next;

  logic        commit;
  logic [2:0]  commit_op;
  logic        commit_eq;

  logic [15:0] mag_ext;
  logic [18:0] digit_sum;

  // mag*10 + d never exceeds 327679, so 19 bits hold it without wrapping
  assign digit_sum = ({4'd0, mag} << 3) + ({4'd0, mag} << 1) + {15'd0, key_digit};

  assign mag_ext     = {1'b0, mag};
  assign entry_value = neg ? (~mag_ext + 16'd1) : mag_ext;
  assign entry_ovf   = ovf;

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    mag_next   = mag;
    neg_next   = neg;
    ovf_next   = ovf;
    commit     = 1'b0;
    commit_op  = 3'b000;
    commit_eq  = 1'b0;

    case (state)
      IDLE: begin
        if (read_input) begin
          capture    = 1'b1;
          state_next = ACK;
        end
      end

      ACK: begin
        state_next = WAIT_LOW;
        if (key_eq) begin
          commit    = 1'b1;
          commit_eq = 1'b1;
        end else if (key_op != 3'b000) begin
          case (key_op)
            OP_SIGN:  neg_next = ~neg;
            OP_CLEAR: begin
              mag_next = 15'd0;
              neg_next = 1'b0;
              ovf_next = 1'b0;
            end
            OP_ADD, OP_SUB, OP_MUL: begin
              commit    = 1'b1;
              commit_op = key_op;
            end
            default: ;
          endcase
        end else if (key_digit <= 4'd9) begin
          if (digit_sum <= 19'd32767)
            mag_next = digit_sum[14:0];
          else
            ovf_next = 1'b1;
        end

        // a committed operand starts a fresh entry
        if (commit) begin
          mag_next = 15'd0;
          neg_next = 1'b0;
          ovf_next = 1'b0;
        end
      end

      WAIT_LOW: begin
        if (!read_input)
          state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      key_read      <= 1'b0;
      key_digit     <= 4'd0;
      key_op        <= 3'b000;
      key_eq        <= 1'b0;
      mag           <= 15'd0;
      neg           <= 1'b0;
      ovf           <= 1'b0;
      operand       <= 16'd0;
      op_code       <= 3'b000;
      is_equal      <= 1'b0;
      operand_valid <= 1'b0;
    end else begin
      state         <= state_next;
      key_read      <= (state_next == ACK);
      mag           <= mag_next;
      neg           <= neg_next;
      ovf           <= ovf_next;
      operand_valid <= commit;
      if (capture) begin
        key_digit <= keypad_input;
        key_op    <= operator_input;
        key_eq    <= equal_input;
      end
      if (commit) begin
        operand  <= entry_value;
        op_code  <= commit_op;
        is_equal <= commit_eq;
      end
    end
  end

endmodule

// File: tb/tb_operand_entry.sv
// Directed self-checking bench for operand_entry; inputs change and outputs
// are sampled on the falling clock edge.
module tb_operand_entry;

  logic        clk;
  logic        rst;
  logic        read_input;
  logic [3:0]  keypad_input;
  logic [2:0]  operator_input;
  logic        equal_input;
  logic        key_read;
  logic [15:0] entry_value;
  logic [15:0] operand;
  logic [2:0]  op_code;
  logic        is_equal;
  logic        operand_valid;
  logic        entry_ovf;

  int checks = 0;
  int errors = 0;
  int kr_cycles = 0;
  int ov_cycles = 0;
  int ov_consec = 0;
  logic ov_prev = 1'b0;
  int kr0;
  int ov0;

  operand_entry dut (
    .clk(clk),
    .rst(rst),
    .read_input(read_input),
    .keypad_input(keypad_input),
    .operator_input(operator_input),
    .equal_input(equal_input),
    .key_read(key_read),
    .entry_value(entry_value),
    .operand(operand),
    .op_code(op_code),
    .is_equal(is_equal),
    .operand_valid(operand_valid),
    .entry_ovf(entry_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse counters used to check handshake and commit counts
  always @(negedge clk) begin
    if (key_read) kr_cycles <= kr_cycles + 1;
    if (operand_valid) ov_cycles <= ov_cycles + 1;
    if (operand_valid && ov_prev) ov_consec <= ov_consec + 1;
    ov_prev <= operand_valid;
  end

  task automatic press_key(input logic [3:0] d, input logic [2:0] op, input logic eq);
    @(negedge clk);
    keypad_input   = d;
    operator_input = op;
    equal_input    = eq;
    read_input     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    read_input = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (key_read !== 1'b0) begin errors++; $display("[TB] FAIL reset_key_read got %b want 0", key_read); end
    checks++; if (operand_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_operand_valid got %b want 0", operand_valid); end
    checks++; if (operand !== 16'h0000) begin errors++; $display("[TB] FAIL reset_operand got %h want 0000", operand); end
    checks++; if (op_code !== 3'b000) begin errors++; $display("[TB] FAIL reset_op_code got %b want 000", op_code); end
    checks++; if (is_equal !== 1'b0) begin errors++; $display("[TB] FAIL reset_is_equal got %b want 0", is_equal); end
    checks++; if (entry_value !== 16'h0000) begin errors++; $display("[TB] FAIL reset_entry_value got %h want 0000", entry_value); end
    checks++; if (entry_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_entry_ovf got %b want 0", entry_ovf); end
    rst = 1'b0;
  endtask

  task automatic test_digits;
    kr0 = kr_cycles;
    press_key(4'd1, 3'b000, 1'b0);
    checks++; if (entry_value !== 16'd1) begin errors++; $display("[TB] FAIL digit_1 got %h want 0001", entry_value); end
    press_key(4'd2, 3'b000, 1'b0);
    checks++; if (entry_value !== 16'd12) begin errors++; $display("[TB] FAIL digit_12 got %h want 000c", entry_value); end
    press_key(4'd3, 3'b000, 1'b0);
    checks++; if (entry_value !== 16'd123) begin errors++; $display("[TB] FAIL digit_123 got %h want 007b", entry_value); end
    checks++; if (kr_cycles - kr0 !== 3) begin errors++; $display("[TB] FAIL digit_key_reads got %0d want 3", kr_cycles - kr0); end
  endtask

  task automatic test_sign_add;
    press_key(4'd0, 3'b110, 1'b0);
    press_key(4'd4, 3'b000, 1'b0);
    press_key(4'd5, 3'b000, 1'b0);
    press_key(4'd0, 3'b001, 1'b0);
    checks++; if (entry_value !== 16'hFFD3) begin errors++; $display("[TB] FAIL sign_neg45 got %h want ffd3", entry_value); end
    ov0 = ov_cycles;
    press_key(4'd0, 3'b010, 1'b0);
    checks++; if (ov_cycles - ov0 !== 1) begin errors++; $display("[TB] FAIL add_valid_pulses got %0d want 1", ov_cycles - ov0); end
    checks++; if (operand !== 16'hFFD3) begin errors++; $display("[TB] FAIL add_operand got %h want ffd3", operand); end
    checks++; if (op_code !== 3'b010) begin errors++; $display("[TB] FAIL add_op_code got %b want 010", op_code); end
    checks++; if (is_equal !== 1'b0) begin errors++; $display("[TB] FAIL add_is_equal got %b want 0", is_equal); end
    checks++; if (entry_value !== 16'h0000) begin errors++; $display("[TB] FAIL add_entry_cleared got %h want 0000", entry_value); end
  endtask

  task automatic test_overflow;
    press_key(4'd3, 3'b000, 1'b0);
    press_key(4'd2, 3'b000, 1'b0);
    press_key(4'd7, 3'b000, 1'b0);
    press_key(4'd6, 3'b000, 1'b0);
    press_key(4'd7, 3'b000, 1'b0);
    checks++; if (entry_value !== 16'h7FFF) begin errors++; $display("[TB] FAIL ovf_max got %h want 7fff", entry_value); end
    checks++; if (entry_ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_not_yet got %b want 0", entry_ovf); end
    press_key(4'd8, 3'b000, 1'b0);
    checks++; if (entry_value !== 16'h7FFF) begin errors++; $display("[TB] FAIL ovf_held got %h want 7fff", entry_value); end
    checks++; if (entry_ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set got %b want 1", entry_ovf); end
    ov0 = ov_cycles;
    press_key(4'd0, 3'b110, 1'b0);
    checks++; if (entry_value !== 16'h0000) begin errors++; $display("[TB] FAIL clear_entry got %h want 0000", entry_value); end
    checks++; if (entry_ovf !== 1'b0) begin errors++; $display("[TB] FAIL clear_ovf got %b want 0", entry_ovf); end
    checks++; if (ov_cycles - ov0 !== 0) begin errors++; $display("[TB] FAIL clear_no_commit got %0d want 0", ov_cycles - ov0); end
  endtask

  task automatic test_held_key;
    kr0 = kr_cycles;
    @(negedge clk);
    keypad_input   = 4'd7;
    operator_input = 3'b000;
    equal_input    = 1'b0;
    read_input     = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (kr_cycles - kr0 !== 1) begin errors++; $display("[TB] FAIL held_key_reads got %0d want 1", kr_cycles - kr0); end
    checks++; if (entry_value !== 16'd7) begin errors++; $display("[TB] FAIL held_entry got %h want 0007", entry_value); end
    read_input = 1'b0;
    repeat (2) @(negedge clk);
    press_key(4'd7, 3'b000, 1'b0);
    checks++; if (entry_value !== 16'd77) begin errors++; $display("[TB] FAIL held_reassert got %h want 004d", entry_value); end
  endtask

  task automatic test_simultaneous;
    press_key(4'd0, 3'b110, 1'b0);
    press_key(4'd9, 3'b000, 1'b0);
    ov0 = ov_cycles;
    press_key(4'd5, 3'b010, 1'b1);
    checks++; if (ov_cycles - ov0 !== 1) begin errors++; $display("[TB] FAIL eq_valid_pulses got %0d want 1", ov_cycles - ov0); end
    checks++; if (operand !== 16'd9) begin errors++; $display("[TB] FAIL eq_operand got %h want 0009", operand); end
    checks++; if (is_equal !== 1'b1) begin errors++; $display("[TB] FAIL eq_is_equal got %b want 1", is_equal); end
    checks++; if (op_code !== 3'b000) begin errors++; $display("[TB] FAIL eq_op_code got %b want 000", op_code); end
    checks++; if (entry_value !== 16'h0000) begin errors++; $display("[TB] FAIL eq_digit_ignored got %h want 0000", entry_value); end
  endtask

  task automatic test_reserved;
    kr0 = kr_cycles;
    press_key(4'd3, 3'b000, 1'b0);
    press_key(4'd0, 3'b101, 1'b0);
    press_key(4'd0, 3'b111, 1'b0);
    press_key(4'd12, 3'b000, 1'b0);
    checks++; if (entry_value !== 16'd3) begin errors++; $display("[TB] FAIL reserved_no_change got %h want 0003", entry_value); end
    checks++; if (kr_cycles - kr0 !== 4) begin errors++; $display("[TB] FAIL reserved_acked got %0d want 4", kr_cycles - kr0); end
    press_key(4'd0, 3'b110, 1'b0);
    press_key(4'd0, 3'b001, 1'b0);
    checks++; if (entry_value !== 16'h0000) begin errors++; $display("[TB] FAIL neg_zero got %h want 0000", entry_value); end
    press_key(4'd5, 3'b000, 1'b0);
    checks++; if (entry_value !== 16'hFFFB) begin errors++; $display("[TB] FAIL neg_then_digit got %h want fffb", entry_value); end
    checks++; if (operand !== 16'd9) begin errors++; $display("[TB] FAIL operand_hold got %h want 0009", operand); end
  endtask

  task automatic test_back_to_back;
    press_key(4'd0, 3'b110, 1'b0);
    press_key(4'd1, 3'b000, 1'b0);
    press_key(4'd0, 3'b100, 1'b0);
    checks++; if (op_code !== 3'b100) begin errors++; $display("[TB] FAIL mul_op_code got %b want 100", op_code); end
    checks++; if (operand !== 16'd1) begin errors++; $display("[TB] FAIL mul_operand got %h want 0001", operand); end
    press_key(4'd0, 3'b000, 1'b1);
    checks++; if (operand !== 16'h0000) begin errors++; $display("[TB] FAIL b2b_eq_operand got %h want 0000", operand); end
    checks++; if (ov_consec !== 0) begin errors++; $display("[TB] FAIL valid_consecutive got %0d want 0", ov_consec); end
  endtask

  task automatic test_reset_in_ack;
    press_key(4'd4, 3'b000, 1'b0);
    ov0 = ov_cycles;
    @(negedge clk);
    keypad_input   = 4'd6;
    operator_input = 3'b000;
    equal_input    = 1'b1;
    read_input     = 1'b1;
    @(negedge clk);
    checks++; if (key_read !== 1'b1) begin errors++; $display("[TB] FAIL ack_key_read got %b want 1", key_read); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (key_read !== 1'b0) begin errors++; $display("[TB] FAIL rst_ack_key_read got %b want 0", key_read); end
    checks++; if (entry_value !== 16'h0000) begin errors++; $display("[TB] FAIL rst_ack_entry got %h want 0000", entry_value); end
    read_input  = 1'b0;
    equal_input = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ov_cycles - ov0 !== 0) begin errors++; $display("[TB] FAIL rst_ack_no_commit got %0d want 0", ov_cycles - ov0); end
    checks++; if (key_read !== 1'b0) begin errors++; $display("[TB] FAIL rst_ack_no_ack got %b want 0", key_read); end
  endtask

  task automatic test_reset_release_high;
    rst            = 1'b1;
    keypad_input   = 4'd2;
    operator_input = 3'b000;
    equal_input    = 1'b0;
    read_input     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (key_read !== 1'b1) begin errors++; $display("[TB] FAIL release_key_read got %b want 1", key_read); end
    @(negedge clk);
    checks++; if (entry_value !== 16'd2) begin errors++; $display("[TB] FAIL release_entry got %h want 0002", entry_value); end
    read_input = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst            = 1'b1;
    read_input     = 1'b0;
    keypad_input   = 4'd0;
    operator_input = 3'b000;
    equal_input    = 1'b0;
    test_reset();
    test_digits();
    test_sign_add();
    test_overflow();
    test_held_key();
    test_simultaneous();
    test_reserved();
    test_back_to_back();
    test_reset_in_ack();
    test_reset_release_high();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk, rst.
REQ-002 Ports SHALL be as follows:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- read_input  in  1  key event present from the keypad scanner; qualifies keypad_input, operator_input and equal_input.
- keypad_input  in  4  digit 0–9.
- operator_input  in  3  001 sign toggle, 010 add, 011 sub, 100 mul, 110 clear entry, others reserved.
- equal_input  in  1  equals key.
- key_read  out  1  one-cycle acknowledge to the scanner.
- entry_value  out  16  signed two's-complement value being typed, for display.
- operand  out  16  signed committed operand.
- op_code  out  3  operator committed with operand; 000 on an equals commit.
- is_equal  out  1  commit was caused by equals.
- operand_valid  out  1  one-cycle commit strobe.
- entry_ovf  out  1  sticky flag: a digit was rejected for range.

Function
REQ-003 The FSM SHALL have three states: IDLE, ACK, WAIT_LOW.
REQ-004 In IDLE with read_input=1, the block SHALL capture all three key fields at that edge and go to ACK; in IDLE with read_input=0 it SHALL remain in IDLE.
REQ-005 key_read SHALL be 1 exactly during the ACK cycle, registered, and 0 in every other state.
REQ-006 In ACK, the captured key SHALL be applied at the edge leaving ACK, and the FSM SHALL go to WAIT_LOW.
REQ-007 WAIT_LOW SHALL go to IDLE on the first edge where read_input=0; a held key SHALL never be applied twice.
REQ-008 Key decode priority SHALL be equal_input, then nonzero operator_input, then digit; lower-priority fields are ignored.
REQ-009 The internal state SHALL be a 15-bit magnitude mag, a sign flag neg and the flag ovf.
REQ-010 entry_value SHALL equal neg ? −mag : mag; −0 SHALL read as 0x0000.
REQ-011 Digit d: if mag*10+d ≤ 32767, mag SHALL become mag*10+d; otherwise mag SHALL be unchanged and ovf SHALL be set.
REQ-012 A keypad_input value greater than 9 SHALL be acknowledged and ignored.
REQ-013 Operator 001 SHALL toggle neg and SHALL be allowed at mag=0.
REQ-014 Operator 110 SHALL clear mag, neg and ovf without committing.
REQ-015 Operators 010, 011 and 100 SHALL commit: operand=entry_value, op_code=operator, is_equal=0, operand_valid=1 for the one cycle after the applying edge; then mag, neg and ovf SHALL clear.
REQ-016 Equals SHALL commit in the same way, with op_code=000 and is_equal=1.
REQ-017 Reserved operators 000, 101 and 111 (read_input=1, non-digit, non-equal path not applicable) SHALL be acknowledged with no state change; operator 000 with equal_input=0 SHALL be treated as a digit.
REQ-018 operand, op_code and is_equal SHALL hold their values until the next commit.
REQ-019 operand_valid SHALL never be asserted on consecutive cycles.
REQ-020 Latency SHALL be as follows:
- read_input seen in IDLE at edge E0.
- key_read high from E0 to E1.
- entry_value and operand_valid update at E1.
- Minimum spacing between accepted keys is 3 cycles.

Reset
REQ-021 With rst=1 at a clock edge, the block SHALL force IDLE; key_read=0, operand_valid=0, operand=0, op_code=000, is_equal=0, entry_value=0, entry_ovf=0, mag=0, neg=0.
REQ-022 Reset SHALL take priority over any key in flight, including in ACK; no key_read or commit SHALL follow reset.
REQ-023 After reset, a read_input already high SHALL be accepted on the first non-reset edge.

Verification
REQ-024 Digit sequence:
- Stimulus: 1,2,3.
- Response: entry_value 1→12→123; exactly one key_read pulse per key.
REQ-025 Sign and add commit:
- Stimulus: 4,5, op 001, op 010.
- Response: entry_value −45; then operand_valid pulse with operand=0xFFD3, op_code=010; entry_value returns to 0.
REQ-026 Overflow:
- Stimulus: 3,2,7,6,7, then 8.
- Response: entry_value 32767 held; entry_ovf=1.
- Then op 110: entry_value=0, entry_ovf=0, no operand_valid.
REQ-027 Held key:
- Stimulus: read_input held high for 20 cycles with digit 7.
- Response: a single key_read; entry_value=7.
- Drop then reassert read_input: entry_value=77.
REQ-028 Simultaneous fields:
- Stimulus: read_input with equal_input=1, operator_input=010, keypad_input=5, entry 9.
- Response: operand=9, is_equal=1, op_code=000; digit 5 not applied.
REQ-029 Reset in ACK:
- Stimulus: rst asserted in the key_read cycle.
- Response: next cycle key_read=0, entry_value=0, no operand_valid.
